aabb_scheduler: RTL and testbench

Front-end controller for the AABB ray/box test engine. It arbitrates between NUM_REQ requesters, assigns each accepted request a tag from a fixed pool, and issues the tagged request to the engine. It captures the engine's tagged results and returns each one to its originating requester, then recycles the tag. All tag bookkeeping is centralised here; the engine only echoes tags back.

---
 rtl/aabb_scheduler_pkg.sv | 37 +++
 rtl/aabb_scheduler_rr_arbiter.sv | 43 ++++
 rtl/aabb_scheduler.sv | 133 +++++++++++++
 tb/tb_aabb_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aabb_scheduler_pkg.sv
// Shared types for the AABB scheduler: packed ray/box request, engine result and tag states.
package aabb_scheduler_pkg;

    localparam int AABB_WIDTH = 16;

    typedef logic signed [AABB_WIDTH-1:0] fixq_t;

    typedef struct packed {
        fixq_t x;
        fixq_t y;
        fixq_t z;
    } vec3_t;

    typedef vec3_t ray_origin_t;
    typedef vec3_t ray_direction_t;
    typedef vec3_t box_min_t;
    typedef vec3_t box_max_t;

    typedef struct packed {
        ray_origin_t    origin;
        ray_direction_t direction;
        box_min_t       box_min;
        box_max_t       box_max;
    } raybox_req_t;

    typedef struct packed {
        logic  hit;
        fixq_t tmin;
    } aabb_result_t;

    typedef enum logic [1:0] {
        TAG_FREE     = 2'd0,
        TAG_INFLIGHT = 2'd1,
        TAG_DONE     = 2'd2
    } tag_state_e;

endpackage

// File: rtl/aabb_scheduler_rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer, pointer moves past the winner on a grant.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    logic [IDX_W-1:0] ptr;
    logic             found;
    int               idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = IDX_W'(idx);
            end
        end
        gnt_any = en && found;
        if (gnt_any) gnt[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/aabb_scheduler.sv
// Tag-pool front end for the AABB engine: arbitrate, tag and issue requests, then return results in tag order.
module aabb_scheduler
    import aabb_scheduler_pkg::*;
#(
    parameter int WIDTH    = AABB_WIDTH,
    parameter int NUM_REQ  = 2,
    parameter int NUM_TAGS = 8,
    parameter int TAG_W    = $clog2(NUM_TAGS),
    parameter int ID_W     = $clog2(NUM_REQ),
    parameter int RAYBOX_W = 12 * WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*RAYBOX_W-1:0] req_pkt,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        iss_valid,
    input  logic                        iss_ready,
    output logic [TAG_W-1:0]            iss_tag,
    output logic [RAYBOX_W-1:0]         iss_pkt,
    input  logic                        ret_valid,
    input  logic [TAG_W-1:0]            ret_tag,
    input  logic                        ret_hit,
    input  logic signed [WIDTH-1:0]     ret_tmin,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ID_W-1:0]             rsp_id,
    output logic [TAG_W-1:0]            rsp_tag,
    output logic                        rsp_hit,
    output logic signed [WIDTH-1:0]     rsp_tmin,
    output logic [TAG_W:0]              inflight_cnt,
    output logic                        err_sticky
);

    tag_state_e       tag_state     [NUM_TAGS];
    tag_state_e       tag_state_nxt [NUM_TAGS];
    logic [ID_W-1:0]  owner         [NUM_TAGS];
    aabb_result_t     result_mem    [NUM_TAGS];

    logic [TAG_W-1:0] free_idx;
    logic [TAG_W-1:0] done_idx;
    logic             any_free;
    logic             any_done;
    logic             grant_en;
    logic             grant;
    logic [ID_W-1:0]  gnt_idx;
    logic             ret_ok;
    logic             rsp_fire;
    logic [TAG_W:0]   cnt_nxt;

    // Lowest-index FREE tag for allocation, lowest-index DONE tag for response
    always_comb begin
        free_idx = '0;
        done_idx = '0;
        any_free = 1'b0;
        any_done = 1'b0;
        for (int t = NUM_TAGS - 1; t >= 0; t--) begin
            if (tag_state[t] == TAG_FREE) begin
                any_free = 1'b1;
                free_idx = TAG_W'(t);
            end
            if (tag_state[t] == TAG_DONE) begin
                any_done = 1'b1;
                done_idx = TAG_W'(t);
            end
        end
    end

    // No grant while reset is held so every output sits at its reset value
    assign grant_en = !reset && any_free && (!iss_valid || iss_ready);

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .en      (grant_en),
        .gnt     (req_ready),
        .gnt_idx (gnt_idx),
        .gnt_any (grant)
    );

    assign ret_ok    = (tag_state[ret_tag] == TAG_INFLIGHT);
    assign rsp_valid = any_done;
    assign rsp_fire  = any_done && rsp_ready;
    assign rsp_tag   = done_idx;
    assign rsp_id    = owner[done_idx];
    assign rsp_hit   = result_mem[done_idx].hit;
    assign rsp_tmin  = result_mem[done_idx].tmin;

    // Allocation, capture and retirement always touch distinct tags
    always_comb begin
        tag_state_nxt = tag_state;
        if (grant) tag_state_nxt[free_idx] = TAG_INFLIGHT;
        if (ret_valid && ret_ok) tag_state_nxt[ret_tag] = TAG_DONE;
        if (rsp_fire) tag_state_nxt[done_idx] = TAG_FREE;
        cnt_nxt = '0;
        for (int t = 0; t < NUM_TAGS; t++) begin
            if (tag_state_nxt[t] != TAG_FREE) cnt_nxt = cnt_nxt + (TAG_W+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < NUM_TAGS; t++) tag_state[t] <= TAG_FREE;
            inflight_cnt <= '0;
            err_sticky   <= 1'b0;
            iss_valid    <= 1'b0;
            iss_tag      <= '0;
            iss_pkt      <= '0;
        end else begin
            tag_state    <= tag_state_nxt;
            inflight_cnt <= cnt_nxt;
            if (ret_valid && !ret_ok) err_sticky <= 1'b1;
            if (grant) begin
                iss_valid <= 1'b1;
                iss_tag   <= free_idx;
                iss_pkt   <= req_pkt[gnt_idx*RAYBOX_W +: RAYBOX_W];
            end else if (iss_ready) begin
                iss_valid <= 1'b0;
            end
        end
    end

    // Per-tag payload storage; only ever read back while its tag is DONE
    always_ff @(posedge clk) begin
        if (grant) owner[free_idx] <= gnt_idx;
        if (ret_valid && ret_ok) result_mem[ret_tag] <= '{hit: ret_hit, tmin: ret_tmin};
    end

endmodule

// File: tb/tb_aabb_scheduler.sv
// Directed plus randomized bench for aabb_scheduler against a tag-pool reference model.
module tb_aabb_scheduler;

    localparam int WIDTH    = 16;
    localparam int NUM_REQ  = 2;
    localparam int NUM_TAGS = 8;
    localparam int TAG_W    = 3;
    localparam int ID_W     = 1;
    localparam int RAYBOX_W = 12 * WIDTH;

    logic                        clk = 1'b0;
    logic                        reset;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*RAYBOX_W-1:0] req_pkt;
    logic [NUM_REQ-1:0]          req_ready;
    logic                        iss_valid;
    logic                        iss_ready;
    logic [TAG_W-1:0]            iss_tag;
    logic [RAYBOX_W-1:0]         iss_pkt;
    logic                        ret_valid;
    logic [TAG_W-1:0]            ret_tag;
    logic                        ret_hit;
    logic signed [WIDTH-1:0]     ret_tmin;
    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [ID_W-1:0]             rsp_id;
    logic [TAG_W-1:0]            rsp_tag;
    logic                        rsp_hit;
    logic signed [WIDTH-1:0]     rsp_tmin;
    logic [TAG_W:0]              inflight_cnt;
    logic                        err_sticky;

    always #5 clk = ~clk;

    aabb_scheduler #(
        .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .NUM_TAGS(NUM_TAGS)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_pkt(req_pkt), .req_ready(req_ready),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_tag(iss_tag), .iss_pkt(iss_pkt),
        .ret_valid(ret_valid), .ret_tag(ret_tag), .ret_hit(ret_hit), .ret_tmin(ret_tmin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
        .rsp_hit(rsp_hit), .rsp_tmin(rsp_tmin),
        .inflight_cnt(inflight_cnt), .err_sticky(err_sticky)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: 0 = free, 1 = waiting for engine, 2 = result held
    int                  m_state [NUM_TAGS];
    int                  m_owner [NUM_TAGS];
    bit                  m_hit   [NUM_TAGS];
    logic [WIDTH-1:0]    m_tmin  [NUM_TAGS];
    int                  m_ptr;
    bit                  m_iv;
    int                  m_itag;
    logic [RAYBOX_W-1:0] m_ipkt;
    bit                  m_err;

    logic [RAYBOX_W-1:0] pkt_a;
    int                  pend [$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int t = 0; t < NUM_TAGS; t++) m_state[t] = 0;
        m_ptr = 0;
        m_iv  = 0;
        m_err = 0;
    endfunction

    task automatic check_and_update();
        int alloc, lowdone, cnt, winner, r;
        logic [NUM_REQ-1:0] exp_ready;
        if (reset) begin
            chk("rst_iss_valid", iss_valid, 0);
            chk("rst_cnt", inflight_cnt, 0);
            chk("rst_err", err_sticky, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            m_reset();
            return;
        end
        alloc = -1; lowdone = -1; cnt = 0; winner = -1;
        for (int t = NUM_TAGS - 1; t >= 0; t--) begin
            if (m_state[t] == 0) alloc = t;
            if (m_state[t] == 2) lowdone = t;
            if (m_state[t] != 0) cnt++;
        end
        if (alloc >= 0 && (!m_iv || iss_ready)) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r = (m_ptr + i) % NUM_REQ;
                if (winner < 0 && req_valid[r]) winner = r;
            end
        end
        exp_ready = '0;
        if (winner >= 0) exp_ready[winner] = 1'b1;

        chk("req_ready", req_ready, exp_ready);
        chk("iss_valid", iss_valid, m_iv);
        if (m_iv) begin
            chk("iss_tag", iss_tag, m_itag);
            chk("iss_pkt", iss_pkt, m_ipkt);
        end
        chk("rsp_valid", rsp_valid, lowdone >= 0);
        if (lowdone >= 0) begin
            chk("rsp_tag", rsp_tag, lowdone);
            chk("rsp_id", rsp_id, m_owner[lowdone]);
            chk("rsp_hit", rsp_hit, m_hit[lowdone]);
            chk("rsp_tmin", $unsigned(rsp_tmin), m_tmin[lowdone]);
        end
        chk("inflight_cnt", inflight_cnt, cnt);
        chk("err_sticky", err_sticky, m_err);

        // Advance the model across the coming clock edge
        if (ret_valid) begin
            if (m_state[ret_tag] == 1) begin
                m_state[ret_tag] = 2;
                m_hit[ret_tag]   = ret_hit;
                m_tmin[ret_tag]  = $unsigned(ret_tmin);
            end else begin
                m_err = 1;
            end
        end
        if (lowdone >= 0 && rsp_ready) m_state[lowdone] = 0;
        if (winner >= 0) begin
            m_state[alloc] = 1;
            m_owner[alloc] = winner;
            m_ptr  = (winner + 1) % NUM_REQ;
            m_iv   = 1;
            m_itag = alloc;
            m_ipkt = req_pkt[winner*RAYBOX_W +: RAYBOX_W];
        end else if (iss_ready) begin
            m_iv = 0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_and_update();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_pkt();
        for (int i = 0; i < NUM_REQ * RAYBOX_W / 32; i++) req_pkt[i*32 +: 32] = $urandom();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0; iss_ready = 1'b0; ret_valid = 1'b0; rsp_ready = 1'b0;
        ret_tag = '0; ret_hit = 1'b0; ret_tmin = '0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req_pkt = '0;
        m_reset();
        do_reset();

        // 1: single request, issue, result, response
        req_valid = 2'b01; rand_pkt(); pkt_a = req_pkt[0 +: RAYBOX_W]; iss_ready = 1'b1;
        #1 chk("t1_req_ready", req_ready, 2'b01);
        cycle();
        req_valid = 2'b00;
        #1;
        chk("t1_iss_valid", iss_valid, 1);
        chk("t1_iss_tag", iss_tag, 0);
        chk("t1_iss_pkt", iss_pkt, pkt_a);
        ret_valid = 1'b1; ret_tag = 3'd0; ret_hit = 1'b1; ret_tmin = 16'sh0800;
        cycle();
        ret_valid = 1'b0;
        #1;
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_id", rsp_id, 0);
        chk("t1_rsp_tag", rsp_tag, 0);
        chk("t1_rsp_hit", rsp_hit, 1);
        chk("t1_rsp_tmin", $unsigned(rsp_tmin), 16'h0800);
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
        #1 chk("t1_cnt_zero", inflight_cnt, 0);

        // 2/3: alternating grants, sequential tags, fill the pool
        do_reset();
        req_valid = 2'b11; iss_ready = 1'b1;
        for (int k = 0; k < NUM_TAGS; k++) begin
            rand_pkt();
            #1 chk("t2_alternate", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            cycle();
            chk("t2_iss_tag", iss_tag, k);
        end
        #1;
        chk("t3_full_ready", req_ready, 2'b00);
        chk("t3_full_cnt", inflight_cnt, NUM_TAGS);
        cycle();
        ret_valid = 1'b1; ret_tag = 3'd5; ret_hit = 1'b0; ret_tmin = 16'sh7123;
        cycle();
        ret_valid = 1'b0;
        #1;
        chk("t3_rsp_tag5", rsp_tag, 5);
        chk("t3_rsp_id5", rsp_id, 1);
        chk("t3_still_full", req_ready, 2'b00);
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
        #1 chk("t3_regrant", req_ready, 2'b01);
        cycle();
        chk("t3_reissue_valid", iss_valid, 1);
        chk("t3_reissue_tag", iss_tag, 5);
        req_valid = 2'b00;

        // 4: issue backpressure holds the register and blocks grants
        do_reset();
        req_valid = 2'b01; iss_ready = 1'b0; rand_pkt(); pkt_a = req_pkt[0 +: RAYBOX_W];
        cycle();
        for (int k = 0; k < 3; k++) begin
            rand_pkt();
            #1;
            chk("t4_hold_tag", iss_tag, 0);
            chk("t4_hold_pkt", iss_pkt, pkt_a);
            chk("t4_no_grant", req_ready, 2'b00);
            cycle();
        end
        iss_ready = 1'b1;
        #1 chk("t4_same_cycle_grant", req_ready, 2'b01);
        cycle();
        chk("t4_next_tag", iss_tag, 1);
        req_valid = 2'b00;
        cycle();

        // 5: out-of-order returns drain in tag order
        do_reset();
        req_valid = 2'b11; iss_ready = 1'b1;
        repeat (3) begin rand_pkt(); cycle(); end
        req_valid = 2'b00;
        cycle();
        ret_valid = 1'b1; ret_tag = 3'd2; ret_hit = 1'b0; ret_tmin = -16'sd300;
        cycle();
        ret_tag = 3'd0; ret_hit = 1'b1; ret_tmin = 16'sh0123;
        cycle();
        ret_valid = 1'b0;
        cycle();
        #1;
        chk("t5_first_tag", rsp_tag, 0);
        chk("t5_first_id", rsp_id, 0);
        chk("t5_first_hit", rsp_hit, 1);
        chk("t5_first_tmin", $unsigned(rsp_tmin), 16'h0123);
        rsp_ready = 1'b1;
        cycle();
        #1;
        chk("t5_second_tag", rsp_tag, 2);
        chk("t5_second_id", rsp_id, 0);
        chk("t5_second_hit", rsp_hit, 0);
        chk("t5_second_tmin", $unsigned(rsp_tmin), 16'hfed4);
        cycle();
        rsp_ready = 1'b0;
        #1;
        chk("t5_drained", rsp_valid, 0);
        chk("t5_cnt", inflight_cnt, 1);

        // 6: stray result, then reset in the middle of traffic
        ret_valid = 1'b1; ret_tag = 3'd7;
        cycle();
        ret_valid = 1'b0;
        #1;
        chk("t6_err", err_sticky, 1);
        chk("t6_cnt_unchanged", inflight_cnt, 1);
        chk("t6_no_rsp", rsp_valid, 0);
        req_valid = 2'b01; iss_ready = 1'b0; rand_pkt();
        cycle();
        cycle();
        #1 reset = 1'b1;
        #1;
        chk("t6_rst_iss_valid", iss_valid, 0);
        chk("t6_rst_iss_tag", iss_tag, 0);
        chk("t6_rst_iss_pkt", iss_pkt, 0);
        chk("t6_rst_cnt", inflight_cnt, 0);
        chk("t6_rst_err", err_sticky, 0);
        chk("t6_rst_req_ready", req_ready, 2'b00);
        chk("t6_rst_rsp_valid", rsp_valid, 0);
        req_valid = 2'b00;
        cycle();
        cycle();
        reset = 1'b0;
        ret_valid = 1'b1; ret_tag = 3'd1;
        cycle();
        ret_valid = 1'b0;
        #1;
        chk("t6_late_ret_err", err_sticky, 1);
        chk("t6_late_ret_cnt", inflight_cnt, 0);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            req_valid = 2'($urandom_range(0, 3));
            rand_pkt();
            iss_ready = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
            ret_hit   = 1'($urandom_range(0, 1));
            ret_tmin  = 16'($urandom());
            pend.delete();
            for (int t = 0; t < NUM_TAGS; t++) if (m_state[t] == 1) pend.push_back(t);
            ret_valid = 1'b0;
            if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
                ret_valid = 1'b1;
                ret_tag   = 3'(pend[$urandom_range(0, pend.size() - 1)]);
            end else if ($urandom_range(0, 49) == 0) begin
                ret_valid = 1'b1;
                ret_tag   = 3'($urandom_range(0, NUM_TAGS - 1));
            end
            if (c == 1000) reset = 1'b1;
            if (c == 1003) reset = 1'b0;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
